// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed byte image, packs it into 32-bit RAM words
// from address 0, then hands the RAM port to the CPU. LOADER_CHECKSUM_EN adds an XOR trailer check.
module program_loader #(
    parameter int SIZE      = 14,
    parameter int MAX_WORDS = 16384
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            reload,
    input  logic            cpu_wrEn,
    input  logic [SIZE-1:0] cpu_addr,
    input  logic [31:0]     cpu_data,
    output logic            ram_wrEn,
    output logic [SIZE-1:0] ram_addr,
    output logic [31:0]     ram_data,
    output logic            cpu_rst,
    output logic            load_done,
    output logic            load_err,
    output logic [15:0]     words_loaded
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, CHK, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, RUN, ERR} state_t;
`endif

    state_t            state_reg;
    logic [15:0]       cnt_reg;
    logic [1:0]        byte_idx_reg;
    logic [SIZE-1:0]   addr_reg;
    logic [15:0]       words_reg;
    logic              cpu_rst_reg;
    logic              load_done_reg;
    logic              load_err_reg;
    logic [31:0]       word_assembled;
    logic [15:0]       len_next;
    logic [15:0]       words_next;
    logic              accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        xor_reg;
`endif

    // in_ready depends only on state; rst masks it so nothing is consumed in the reset cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            LEN_LO, LEN_HI, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            CHK:                  in_ready = 1'b1;
`endif
            default:              in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept     = in_valid & in_ready;
    assign len_next   = {in_data, cnt_reg[7:0]};
    assign words_next = words_reg + 16'd1;

    // One register per byte lane; the lane selected by byte_idx_reg captures the accepted byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'h00;
                end else if (state_reg == DATA && accept && byte_idx_reg == 2'(gi)) begin
                    lane_reg <= in_data;
                end
            end
            assign word_assembled[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= LEN_LO;
            cnt_reg       <= 16'h0000;
            byte_idx_reg  <= 2'd0;
            addr_reg      <= '0;
            words_reg     <= 16'h0000;
            cpu_rst_reg   <= 1'b1;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_reg       <= 8'h00;
`endif
        end else begin
`ifdef LOADER_CHECKSUM_EN
            if (accept) begin
                xor_reg <= xor_reg ^ in_data;
            end
`endif
            case (state_reg)
                LEN_LO: begin
                    if (accept) begin
                        cnt_reg[7:0] <= in_data;
                        state_reg    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        cnt_reg[15:8] <= in_data;
                        addr_reg      <= '0;
                        words_reg     <= 16'h0000;
                        byte_idx_reg  <= 2'd0;
                        if (int'(len_next) > MAX_WORDS) begin
                            state_reg    <= ERR;
                            load_err_reg <= 1'b1;
                        end else if (len_next == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
                            state_reg     <= CHK;
`else
                            state_reg     <= RUN;
                            cpu_rst_reg   <= 1'b0;
                            load_done_reg <= 1'b1;
`endif
                        end else begin
                            state_reg <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        byte_idx_reg <= byte_idx_reg + 2'd1;
                        if (byte_idx_reg == 2'd3) begin
                            state_reg <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    addr_reg  <= addr_reg + 1'b1;
                    words_reg <= words_next;
                    // Compared on the 16-bit count so a full 2**SIZE image cannot alias to 0.
                    if (words_next == cnt_reg) begin
`ifdef LOADER_CHECKSUM_EN
                        state_reg     <= CHK;
`else
                        state_reg     <= RUN;
                        cpu_rst_reg   <= 1'b0;
                        load_done_reg <= 1'b1;
`endif
                    end else begin
                        state_reg <= DATA;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (in_data == xor_reg) begin
                            state_reg     <= RUN;
                            cpu_rst_reg   <= 1'b0;
                            load_done_reg <= 1'b1;
                        end else begin
                            state_reg    <= ERR;
                            load_err_reg <= 1'b1;
                        end
                    end
                end
`endif
                RUN: begin
                    if (reload) begin
                        state_reg     <= LEN_LO;
                        cpu_rst_reg   <= 1'b1;
                        load_done_reg <= 1'b0;
                        words_reg     <= 16'h0000;
                        addr_reg      <= '0;
                        byte_idx_reg  <= 2'd0;
                        cnt_reg       <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
                        xor_reg       <= 8'h00;
`endif
                    end
                end
                ERR: begin
                    state_reg <= ERR;
                end
                default: begin
                    state_reg <= LEN_LO;
                end
            endcase
        end
    end

    // RAM port: loader owns it in WRITE, the CPU owns it in RUN, otherwise idle.
    always_comb begin
        ram_wrEn = 1'b0;
        ram_addr = '0;
        ram_data = 32'h0000_0000;
        if (state_reg == WRITE) begin
            ram_wrEn = 1'b1;
            ram_addr = addr_reg;
            ram_data = word_assembled;
        end else if (state_reg == RUN) begin
            ram_wrEn = cpu_wrEn;
            ram_addr = cpu_addr;
            ram_data = cpu_data;
        end
    end

    assign cpu_rst      = cpu_rst_reg;
    assign load_done    = load_done_reg;
    assign load_err     = load_err_reg;
    assign words_loaded = words_reg;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; acts as the RAM and the byte source.
module tb_program_loader;
    localparam int SIZE = 14;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      in_data = 8'h00;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            reload = 1'b0;
    logic            cpu_wrEn = 1'b0;
    logic [SIZE-1:0] cpu_addr = '0;
    logic [31:0]     cpu_data = 32'h0;
    logic            ram_wrEn;
    logic [SIZE-1:0] ram_addr;
    logic [31:0]     ram_data;
    logic            cpu_rst;
    logic            load_done;
    logic            load_err;
    logic [15:0]     words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem_model [0:(1<<SIZE)-1];
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          acc_q[$];
    logic [7:0]  stream_q[$];

    program_loader #(.SIZE(SIZE), .MAX_WORDS(16384)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .reload(reload), .cpu_wrEn(cpu_wrEn), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_data(ram_data), .cpu_rst(cpu_rst),
        .load_done(load_done), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // RAM model and write logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_wrEn === 1'b1) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(ram_data);
            wr_cyc_q.push_back(cyc);
            mem_model[ram_addr] = ram_data;
            if (load_done !== 1'b1) check("in_ready_in_write", 32'(in_ready), 32'd0);
        end
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); acc_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output int acc);
        bit done;
        done = 1'b0;
        acc = -1;
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                acc = cyc;
                done = 1'b1;
                @(posedge clk);
            end else begin
                @(negedge clk);
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gap);
        int acc;
        foreach (stream_q[i]) begin
            send_byte(stream_q[i], acc);
            acc_q.push_back(acc);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stream_q.push_back(w[i*8 +: 8]);
    endtask

    // Appends the XOR trailer when the checksum build is in use.
    task automatic add_trailer(input bit corrupt);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (stream_q[i]) x = x ^ stream_q[i];
        stream_q.push_back(corrupt ? ~x : x);
`else
        if (corrupt) stream_q.push_back(8'h00);
`endif
    endtask

    task automatic build_test_image();
        stream_q.delete();
        stream_q.push_back(8'h02);
        stream_q.push_back(8'h00);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        add_trailer(1'b0);
    endtask

    task automatic do_reset(input bit with_checks);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        if (with_checks) check("ready_during_rst", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        if (with_checks) begin
            check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_ram_wrEn", 32'(ram_wrEn), 32'd0);
            check("rst_load_done", 32'(load_done), 32'd0);
            check("rst_words", 32'(words_loaded), 32'd0);
        end
    endtask

    task automatic wait_run(input string tag);
        logic prev_rst;
        bit seen;
        seen = 1'b0;
        prev_rst = cpu_rst;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (load_done === 1'b1) begin
                seen = 1'b1;
                check({tag, "_cpu_rst_first_run"}, 32'(cpu_rst), 32'd0);
                check({tag, "_cpu_rst_before_run"}, 32'(prev_rst), 32'd1);
            end
            prev_rst = cpu_rst;
        end
        if (!seen) check({tag, "_run_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_two_word_load(input string tag);
        check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check({tag, "_addr0"}, 32'(wr_addr_q[0]), 32'd0);
            check({tag, "_data0"}, wr_data_q[0], 32'h12345678);
            check({tag, "_addr1"}, 32'(wr_addr_q[1]), 32'd1);
            check({tag, "_data1"}, wr_data_q[1], 32'hDEADBEEF);
            check({tag, "_lat0"}, 32'(wr_cyc_q[0]), 32'(acc_q[5] + 1));
            check({tag, "_lat1"}, 32'(wr_cyc_q[1]), 32'(acc_q[9] + 1));
        end
        check({tag, "_ram0"}, mem_model[0], 32'h12345678);
        check({tag, "_ram1"}, mem_model[1], 32'hDEADBEEF);
        check({tag, "_words"}, 32'(words_loaded), 32'd2);
        check({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        foreach (mem_model[i]) mem_model[i] = 32'h0;

        // Reset state
        do_reset(1'b1);

        // Back-to-back two-word image
        clear_logs();
        build_test_image();
        send_stream(1'b0);
        wait_run("t2");
        check_two_word_load("t2");

        // CPU pass-through in RUN, then reload
        @(negedge clk);
        cpu_wrEn = 1'b1; cpu_addr = 14'h0005; cpu_data = 32'hA5A5A5A5;
        #1;
        check("t5_ram_wrEn", 32'(ram_wrEn), 32'd1);
        check("t5_ram_addr", 32'(ram_addr), 32'h5);
        check("t5_ram_data", ram_data, 32'hA5A5A5A5);
        @(negedge clk);
        cpu_wrEn = 1'b0;
        reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
        @(negedge clk);
        check("t5_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t5_load_done", 32'(load_done), 32'd0);
        check("t5_words", 32'(words_loaded), 32'd0);
        check("t5_in_ready", 32'(in_ready), 32'd1);
        cpu_wrEn = 1'b1;
        #1;
        check("t5_cpu_blocked", 32'(ram_wrEn), 32'd0);
        check("t5_addr_idle", 32'(ram_addr), 32'd0);
        cpu_wrEn = 1'b0;

        // Same image with a gap after every byte
        foreach (mem_model[i]) mem_model[i] = 32'h0;
        clear_logs();
        build_test_image();
        send_stream(1'b1);
        wait_run("t3");
        check_two_word_load("t3");

        // Reset mid-word, then a fresh one-word image
        do_reset(1'b0);
        foreach (mem_model[i]) mem_model[i] = 32'h0;
        clear_logs();
        stream_q.delete();
        stream_q.push_back(8'h02); stream_q.push_back(8'h00);
        push_word(32'h12345678);
        stream_q.push_back(8'hEF); stream_q.push_back(8'hBE);
        send_stream(1'b0);
        do_reset(1'b0);
        stream_q.delete();
        stream_q.push_back(8'h01); stream_q.push_back(8'h00);
        push_word(32'h44332211);
        add_trailer(1'b0);
        send_stream(1'b0);
        wait_run("t6");
        check("t6_nwrites", 32'(wr_addr_q.size()), 32'd2);
        if (wr_addr_q.size() >= 2) begin
            check("t6_addr", 32'(wr_addr_q[1]), 32'd0);
            check("t6_data", wr_data_q[1], 32'h44332211);
        end
        check("t6_ram0", mem_model[0], 32'h44332211);
        check("t6_ram1_untouched", mem_model[1], 32'h0);
        check("t6_words", 32'(words_loaded), 32'd1);

        // Oversized length
        do_reset(1'b0);
        clear_logs();
        stream_q.delete();
        stream_q.push_back(8'h01); stream_q.push_back(8'h40);
        send_stream(1'b0);
        @(negedge clk);
        check("t4_load_err", 32'(load_err), 32'd1);
        check("t4_in_ready", 32'(in_ready), 32'd0);
        check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t4_load_done", 32'(load_done), 32'd0);
        hits = 0;
        in_data = 8'h55; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (in_ready) hits++;
        end
        in_valid = 1'b0;
        check("t4_stays_blocked", 32'(hits), 32'd0);
        check("t4_no_write", 32'(wr_addr_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum trailer
        do_reset(1'b0);
        clear_logs();
        stream_q.delete();
        stream_q.push_back(8'h02); stream_q.push_back(8'h00);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
        stream_q.push_back(8'h00);
        send_stream(1'b0);
        repeat (2) @(negedge clk);
        check("t7_load_err", 32'(load_err), 32'd1);
        check("t7_cpu_rst", 32'(cpu_rst), 32'd1);
        check("t7_load_done", 32'(load_done), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
